// File: rtl/put_list_drain_if.sv
// put_list_drain_if: bundles the drain command, list-buffer pop port and
// line-write port of put_list_drain.
//   slave  : the drain block (accepts commands, pops lists, offers lines)
//   master : the environment (issues commands, holds lists, sinks lines)
// Signals:
//   cmd_valid_i/cmd_ready_o/cmd_list_i/cmd_beats_i  drain command handshake
//   lb_valid_i                                      per-list non-empty flags
//   lb_pop_valid_o/lb_pop_list_o                    pop strobe and list index
//   lb_data_i/lb_mask_i/lb_opcode_i/lb_source_i     head beat of popped list
//   wr_valid_o/wr_ready_i/wr_data_o/wr_mask_o/
//   wr_opcode_o/wr_source_o                         assembled line handshake
//   busy_o                                          block not idle
interface put_list_drain_if #(
  parameter int unsigned PUTLISTS    = 4,
  parameter int unsigned LIST_BITS   = 2,
  parameter int unsigned MAX_BEATS   = 4,
  parameter int unsigned CNT_BITS    = 3,
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned MASK_BITS   = 8,
  parameter int unsigned OP_BITS     = 3,
  parameter int unsigned SOURCE_BITS = 8
);
  logic                             cmd_valid_i;
  logic                             cmd_ready_o;
  logic [LIST_BITS-1:0]             cmd_list_i;
  logic [CNT_BITS-1:0]              cmd_beats_i;
  logic [PUTLISTS-1:0]              lb_valid_i;
  logic                             lb_pop_valid_o;
  logic [LIST_BITS-1:0]             lb_pop_list_o;
  logic [DATA_BITS-1:0]             lb_data_i;
  logic [MASK_BITS-1:0]             lb_mask_i;
  logic [OP_BITS-1:0]               lb_opcode_i;
  logic [SOURCE_BITS-1:0]           lb_source_i;
  logic                             wr_valid_o;
  logic                             wr_ready_i;
  logic [MAX_BEATS*DATA_BITS-1:0]   wr_data_o;
  logic [MAX_BEATS*MASK_BITS-1:0]   wr_mask_o;
  logic [OP_BITS-1:0]               wr_opcode_o;
  logic [SOURCE_BITS-1:0]           wr_source_o;
  logic                             busy_o;

  modport slave (
    input  cmd_valid_i, cmd_list_i, cmd_beats_i,
    input  lb_valid_i, lb_data_i, lb_mask_i, lb_opcode_i, lb_source_i,
    input  wr_ready_i,
    output cmd_ready_o, lb_pop_valid_o, lb_pop_list_o,
    output wr_valid_o, wr_data_o, wr_mask_o, wr_opcode_o, wr_source_o,
    output busy_o
  );

  modport master (
    output cmd_valid_i, cmd_list_i, cmd_beats_i,
    output lb_valid_i, lb_data_i, lb_mask_i, lb_opcode_i, lb_source_i,
    output wr_ready_i,
    input  cmd_ready_o, lb_pop_valid_o, lb_pop_list_o,
    input  wr_valid_o, wr_data_o, wr_mask_o, wr_opcode_o, wr_source_o,
    input  busy_o
  );
endinterface

// File: rtl/put_list_drain.sv
// put_list_drain: pops one put list beat by beat and assembles a full-line
// write (data + per-byte mask, opcode/source of the first beat), then offers
// it to the data-array write port over valid/ready.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    put_list_drain_if.slave (command, list-buffer pop, line write)
module put_list_drain #(
  parameter int unsigned PUTLISTS    = 4,
  parameter int unsigned LIST_BITS   = 2,
  parameter int unsigned MAX_BEATS   = 4,
  parameter int unsigned CNT_BITS    = 3,
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned MASK_BITS   = 8,
  parameter int unsigned OP_BITS     = 3,
  parameter int unsigned SOURCE_BITS = 8
) (
  input logic            clk,
  input logic            rst_n,
  put_list_drain_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, OUT} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [LIST_BITS-1:0]           list_q;
  logic [CNT_BITS-1:0]            count_q;
  logic [CNT_BITS-1:0]            beat_cnt;
  logic [CNT_BITS-1:0]            beats_clamped;
  logic [MAX_BEATS*DATA_BITS-1:0] data_q;
  logic [MAX_BEATS*MASK_BITS-1:0] mask_q;
  logic [OP_BITS-1:0]             opcode_q;
  logic [SOURCE_BITS-1:0]         source_q;
  logic                           cmd_fire;
  logic                           pop;
  logic                           last_pop;
  logic                           wr_fire;

  always_comb begin
    beats_clamped = (bus.cmd_beats_i > CNT_BITS'(MAX_BEATS)) ? CNT_BITS'(MAX_BEATS)
                                                             : bus.cmd_beats_i;
    cmd_fire = (state == IDLE) && bus.cmd_valid_i;
    // Pop is gated by the buffer's own valid flag, so an empty list is never popped.
    pop      = (state == DRAIN) && bus.lb_valid_i[list_q];
    last_pop = pop && (beat_cnt == count_q - CNT_BITS'(1));
    wr_fire  = (state == OUT) && bus.wr_ready_i;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cmd_fire) state_next = (beats_clamped == '0) ? OUT : DRAIN;
      DRAIN: if (last_pop) state_next = OUT;
      OUT:   if (wr_fire)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.cmd_ready_o    = (state == IDLE);
    bus.busy_o         = (state != IDLE);
    bus.lb_pop_valid_o = pop;
    bus.lb_pop_list_o  = list_q;
    bus.wr_valid_o     = (state == OUT);
    bus.wr_data_o      = data_q;
    bus.wr_mask_o      = mask_q;
    bus.wr_opcode_o    = opcode_q;
    bus.wr_source_o    = source_q;
  end

  // Line assembly; a new command clears the line so undrained slots stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q   <= '0;
      count_q  <= '0;
      beat_cnt <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      opcode_q <= '0;
      source_q <= '0;
    end else if (cmd_fire) begin
      list_q   <= bus.cmd_list_i;
      count_q  <= beats_clamped;
      beat_cnt <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      opcode_q <= '0;
      source_q <= '0;
    end else if (pop) begin
      // Slot select by compare keeps part-select bounds constant.
      for (int unsigned k = 0; k < MAX_BEATS; k++) begin
        if (beat_cnt == CNT_BITS'(k)) begin
          data_q[k*DATA_BITS +: DATA_BITS] <= bus.lb_data_i;
          mask_q[k*MASK_BITS +: MASK_BITS] <= bus.lb_mask_i;
        end
      end
      if (beat_cnt == '0) begin
        opcode_q <= bus.lb_opcode_i;
        source_q <= bus.lb_source_i;
      end
      beat_cnt <= beat_cnt + CNT_BITS'(1);
    end
  end

endmodule
